// File: rtl/bullet_manager.sv
// Bullet pool for the player tank: edge-triggered launches, per-frame motion with
// edge bounce, lifetime expiry and enemy hit detection.
module bullet_manager #(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 16,
    parameter int LIFETIME    = 300,
    parameter int COOLDOWN    = 15
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic [1:0]               game_end,
    input  logic                     ShootBullet,
    input  logic [9:0]               TankX,
    input  logic [9:0]               TankY,
    input  logic [7:0]               sin,
    input  logic [7:0]               cos,
    input  logic [9:0]               EnemyX,
    input  logic [9:0]               EnemyY,
    input  logic [9:0]               EnemyS,
    output logic [10*NUM_BULLETS-1:0] BulletX,
    output logic [10*NUM_BULLETS-1:0] BulletY,
    output logic [NUM_BULLETS-1:0]   BulletActive,
    output logic                     fire_ack,
    output logic                     hit_enemy
);

    localparam int          CW    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [12:0] X_MAX = 13'd5112;
    localparam logic [12:0] Y_MAX = 13'd3832;

    logic [NUM_BULLETS-1:0] active_q, active_d;
    logic [12:0]            x_q [NUM_BULLETS];
    logic [12:0]            x_d [NUM_BULLETS];
    logic [12:0]            y_q [NUM_BULLETS];
    logic [12:0]            y_d [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] vx_neg_q, vx_neg_d;
    logic [NUM_BULLETS-1:0] vy_neg_q, vy_neg_d;
    logic [7:0]             vx_mag_q [NUM_BULLETS];
    logic [7:0]             vx_mag_d [NUM_BULLETS];
    logic [7:0]             vy_mag_q [NUM_BULLETS];
    logic [7:0]             vy_mag_d [NUM_BULLETS];
    logic [8:0]             life_q [NUM_BULLETS];
    logic [8:0]             life_d [NUM_BULLETS];
    logic [CW-1:0]          cool_q, cool_d;
    logic                   shoot_prev_q, shoot_prev_d;
    logic                   fire_ack_q, fire_ack_d;
    logic                   hit_q, hit_d;

    logic [14:0] vx_prod, vy_prod;
    logic [7:0]  launch_vx_mag, launch_vy_mag;
    logic        accept, hit_i, hit_any, slot_found;

    function automatic logic near(input logic [9:0] a, input logic [9:0] b, input logic [9:0] lim);
        return ((a >= b) ? (a - b) : (b - a)) <= lim;
    endfunction

    // One axis step; returns {negative_direction, new_position}. Wider than the
    // position so launches from beyond the playfield cannot wrap.
    function automatic logic [13:0] step_axis(input logic [12:0] pos, input logic neg,
                                              input logic [7:0] mag, input logic [12:0] lim);
        logic signed [14:0] nxt;
        nxt = neg ? ($signed({2'b00, pos}) - $signed({7'b0, mag}))
                  : ($signed({2'b00, pos}) + $signed({7'b0, mag}));
        if (nxt < 15'sd0)
            return {1'b0, 13'd0};
        else if (nxt > $signed({2'b00, lim}))
            return {1'b1, lim};
        else
            return {neg, 13'(nxt)};
    endfunction

    assign vx_prod       = 15'(SPEED) * {8'd0, cos[6:0]};
    assign vy_prod       = 15'(SPEED) * {8'd0, sin[6:0]};
    assign launch_vx_mag = 8'(vx_prod >> 7);
    assign launch_vy_mag = 8'(vy_prod >> 7);

    always_comb begin
        active_d     = active_q;
        x_d          = x_q;
        y_d          = y_q;
        vx_neg_d     = vx_neg_q;
        vy_neg_d     = vy_neg_q;
        vx_mag_d     = vx_mag_q;
        vy_mag_d     = vy_mag_q;
        life_d       = life_q;
        hit_i        = 1'b0;
        hit_any      = 1'b0;
        slot_found   = 1'b0;
        shoot_prev_d = ShootBullet;
        accept       = ShootBullet && !shoot_prev_q && (cool_q == '0) && !(&active_q);

        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (active_q[i]) begin
                hit_i     = near(x_q[i][12:3], EnemyX, EnemyS) && near(y_q[i][12:3], EnemyY, EnemyS);
                hit_any   = hit_any | hit_i;
                life_d[i] = life_q[i] - 9'd1;
                if (hit_i || (life_q[i] <= 9'd1)) begin
                    active_d[i] = 1'b0;
                end else begin
                    {vx_neg_d[i], x_d[i]} = step_axis(x_q[i], vx_neg_q[i], vx_mag_q[i], X_MAX);
                    {vy_neg_d[i], y_d[i]} = step_axis(y_q[i], vy_neg_q[i], vy_mag_q[i], Y_MAX);
                end
            end
        end

        // Freedom is judged on the registered flags, so a slot retiring now stays unavailable.
        if (accept) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (!active_q[i] && !slot_found) begin
                    slot_found  = 1'b1;
                    active_d[i] = 1'b1;
                    x_d[i]      = {TankX, 3'b000};
                    y_d[i]      = {TankY, 3'b000};
                    vx_neg_d[i] = cos[7];
                    vx_mag_d[i] = launch_vx_mag;
                    vy_neg_d[i] = ~sin[7];
                    vy_mag_d[i] = launch_vy_mag;
                    life_d[i]   = 9'(LIFETIME);
                end
            end
        end

        fire_ack_d = accept;
        hit_d      = hit_any;
        if (accept)
            cool_d = CW'(COOLDOWN);
        else if (cool_q != '0)
            cool_d = cool_q - 1'b1;
        else
            cool_d = cool_q;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset || (game_end != 2'b00)) begin
            active_q     <= '0;
            vx_neg_q     <= '0;
            vy_neg_q     <= '0;
            cool_q       <= '0;
            shoot_prev_q <= 1'b0;
            fire_ack_q   <= 1'b0;
            hit_q        <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i]      <= '0;
                y_q[i]      <= '0;
                vx_mag_q[i] <= '0;
                vy_mag_q[i] <= '0;
                life_q[i]   <= '0;
            end
        end else begin
            active_q     <= active_d;
            vx_neg_q     <= vx_neg_d;
            vy_neg_q     <= vy_neg_d;
            cool_q       <= cool_d;
            shoot_prev_q <= shoot_prev_d;
            fire_ack_q   <= fire_ack_d;
            hit_q        <= hit_d;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i]      <= x_d[i];
                y_q[i]      <= y_d[i];
                vx_mag_q[i] <= vx_mag_d[i];
                vy_mag_q[i] <= vy_mag_d[i];
                life_q[i]   <= life_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
        assign BulletX[10*g +: 10] = x_q[g][12:3];
        assign BulletY[10*g +: 10] = y_q[g][12:3];
    end

    assign BulletActive = active_q;
    assign fire_ack     = fire_ack_q;
    assign hit_enemy    = hit_q;

endmodule

// File: tb/tb_bullet_manager.sv
// Scoreboard bench for bullet_manager: a frame-level reference model queues expected
// launch/hit pulses, a negedge monitor pops and compares them and tracks slot state.
module tb_bullet_manager;

    localparam int NB = 4;
    localparam int SPEED = 16;
    localparam int LIFETIME = 300;
    localparam int COOLDOWN = 15;

    logic            frame_clk = 1'b0;
    logic            Reset;
    logic [1:0]      game_end;
    logic            ShootBullet;
    logic [9:0]      TankX, TankY, EnemyX, EnemyY, EnemyS;
    logic [7:0]      sin, cos;
    logic [10*NB-1:0] BulletX, BulletY;
    logic [NB-1:0]   BulletActive;
    logic            fire_ack, hit_enemy;

    typedef struct {
        int due;
        int slot;
        int px;
        int py;
    } fire_t;

    fire_t exp_fire[$];
    int    exp_hit[$];

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int fires_seen = 0;
    int hits_seen = 0;

    int m_act[NB], m_x[NB], m_y[NB], m_vx[NB], m_vy[NB], m_life[NB];
    int m_cool = 0;
    int m_prev = 0;

    bullet_manager #(.NUM_BULLETS(NB), .SPEED(SPEED), .LIFETIME(LIFETIME), .COOLDOWN(COOLDOWN)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .game_end(game_end), .ShootBullet(ShootBullet),
        .TankX(TankX), .TankY(TankY), .sin(sin), .cos(cos),
        .EnemyX(EnemyX), .EnemyY(EnemyY), .EnemyS(EnemyS),
        .BulletX(BulletX), .BulletY(BulletY), .BulletActive(BulletActive),
        .fire_ack(fire_ack), .hit_enemy(hit_enemy)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic axis_step(input int p, input int v, input int lim, output int np, output int nv);
        int n;
        n = p + v;
        nv = v;
        if (n < 0) begin
            np = 0;
            nv = iabs(v);
        end else if (n > lim) begin
            np = lim;
            nv = -iabs(v);
        end else begin
            np = n;
        end
    endtask

    // Reference model: applies the frame rules to the inputs seen at each edge.
    always @(posedge frame_clk) begin : model
        int req, free_slot, hit_now, h, mag, np, nv;
        fire_t f;
        edge_cnt++;
        if (Reset || game_end != 2'b00) begin
            for (int i = 0; i < NB; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0;
            end
            m_cool = 0;
            m_prev = 0;
        end else begin
            req = (ShootBullet && !m_prev) ? 1 : 0;
            m_prev = ShootBullet ? 1 : 0;
            free_slot = -1;
            for (int i = NB - 1; i >= 0; i--)
                if (!m_act[i]) free_slot = i;
            hit_now = 0;
            for (int i = 0; i < NB; i++) begin
                if (m_act[i]) begin
                    h = (iabs(m_x[i] / 8 - int'(EnemyX)) <= int'(EnemyS)) &&
                        (iabs(m_y[i] / 8 - int'(EnemyY)) <= int'(EnemyS));
                    if (h) hit_now = 1;
                    m_life[i]--;
                    if (h || m_life[i] == 0) begin
                        m_act[i] = 0;
                    end else begin
                        axis_step(m_x[i], m_vx[i], 639 * 8, np, nv);
                        m_x[i] = np; m_vx[i] = nv;
                        axis_step(m_y[i], m_vy[i], 479 * 8, np, nv);
                        m_y[i] = np; m_vy[i] = nv;
                    end
                end
            end
            if (req && m_cool == 0 && free_slot >= 0) begin
                m_act[free_slot]  = 1;
                m_x[free_slot]    = int'(TankX) * 8;
                m_y[free_slot]    = int'(TankY) * 8;
                mag               = (SPEED * int'(cos[6:0])) / 128;
                m_vx[free_slot]   = cos[7] ? -mag : mag;
                mag               = (SPEED * int'(sin[6:0])) / 128;
                m_vy[free_slot]   = sin[7] ? mag : -mag;
                m_life[free_slot] = LIFETIME;
                m_cool            = COOLDOWN;
                f.due = edge_cnt; f.slot = free_slot; f.px = int'(TankX); f.py = int'(TankY);
                exp_fire.push_back(f);
            end else if (m_cool > 0) begin
                m_cool--;
            end
            if (hit_now) exp_hit.push_back(edge_cnt);
        end
    end

    // Monitor: pops the scoreboard whenever a pulse appears or one is due.
    always @(negedge frame_clk) begin : monitor
        fire_t f;
        if (edge_cnt >= 1) begin
            if (fire_ack === 1'b1) fires_seen++;
            if (hit_enemy === 1'b1) hits_seen++;
            if (fire_ack === 1'b1 || (exp_fire.size() > 0 && exp_fire[0].due <= edge_cnt)) begin
                if (exp_fire.size() == 0) begin
                    check_output("fire_unexpected", 32'(fire_ack), 0);
                end else begin
                    f = exp_fire.pop_front();
                    check_output("fire_pulse", 32'(fire_ack), 1);
                    check_output("fire_slot_x", 32'(BulletX[10*f.slot +: 10]), 32'(f.px));
                    check_output("fire_slot_y", 32'(BulletY[10*f.slot +: 10]), 32'(f.py));
                end
            end
            if (hit_enemy === 1'b1 || (exp_hit.size() > 0 && exp_hit[0] <= edge_cnt)) begin
                if (exp_hit.size() == 0) begin
                    check_output("hit_unexpected", 32'(hit_enemy), 0);
                end else begin
                    void'(exp_hit.pop_front());
                    check_output("hit_pulse", 32'(hit_enemy), 1);
                end
            end
            for (int i = 0; i < NB; i++) begin
                check_output("slot_active", 32'(BulletActive[i]), 32'(m_act[i]));
                if (m_act[i]) begin
                    check_output("slot_x", 32'(BulletX[10*i +: 10]), 32'(m_x[i] / 8));
                    check_output("slot_y", 32'(BulletY[10*i +: 10]), 32'(m_y[i] / 8));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic shoot, input int tx, input int ty,
                                  input logic [7:0] s, input logic [7:0] c);
        ShootBullet = shoot;
        TankX = 10'(tx);
        TankY = 10'(ty);
        sin = s;
        cos = c;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
    endtask

    task automatic enemy_far();
        EnemyX = 10'd1000;
        EnemyY = 10'd1000;
        EnemyS = 10'd0;
    endtask

    int base;

    initial begin
        Reset = 1'b1;
        game_end = 2'b00;
        apply_stimulus(1'b0, 0, 0, 8'h00, 8'h00);
        enemy_far();
        tick(2);
        check_output("reset_active", 32'(BulletActive), 0);
        check_output("reset_fire_ack", 32'(fire_ack), 0);
        check_output("reset_hit", 32'(hit_enemy), 0);
        Reset = 1'b0;

        // Straight shot, then hold the button: a single launch only.
        apply_stimulus(1'b1, 300, 250, 8'h00, 8'h7F);
        tick(1);
        check_output("straight_launch_x", 32'(BulletX[9:0]), 300);
        check_output("straight_fire_ack", 32'(fire_ack), 1);
        tick(8);
        check_output("straight_x_8", 32'(BulletX[9:0]), 315);
        check_output("straight_y_8", 32'(BulletY[9:0]), 250);
        tick(20);
        check_output("hold_one_launch", 32'(BulletActive), 4'b0001);
        ShootBullet = 1'b0;
        tick(1);

        // Right-edge bounce.
        apply_stimulus(1'b1, 638, 250, 8'h00, 8'h7F);
        tick(1);
        check_output("bounce_launch_x", 32'(BulletX[19:10]), 638);
        tick(1);
        check_output("bounce_clamp_x", 32'(BulletX[19:10]), 639);
        tick(1);
        check_output("bounce_back_x", 32'(BulletX[19:10]), 637);
        ShootBullet = 1'b0;

        // Reset with three live bullets, relaunch two cycles later into slot 0.
        tick(16);
        apply_stimulus(1'b1, 200, 200, 8'h40, 8'h40);
        tick(1);
        ShootBullet = 1'b0;
        check_output("three_live", 32'(BulletActive), 4'b0111);
        pulse_reset();
        check_output("midflight_reset_active", 32'(BulletActive), 0);
        check_output("midflight_reset_fire", 32'(fire_ack), 0);
        tick(2);
        ShootBullet = 1'b1;
        tick(1);
        ShootBullet = 1'b0;
        check_output("relaunch_slot0", 32'(BulletActive), 4'b0001);

        // Cooldown and pool exhaustion with a request edge every other frame.
        pulse_reset();
        base = fires_seen;
        for (int k = 0; k < 310; k++) begin
            apply_stimulus((k % 2) == 0, 100, 100, 8'h00, 8'h7F);
            tick(1);
            if (k == 69) check_output("pool_four_launches", 32'(fires_seen - base), 4);
        end
        check_output("reuse_after_expiry", 32'(fires_seen - base), 5);
        check_output("pool_refilled", 32'(BulletActive), 4'b1111);
        ShootBullet = 1'b0;

        // Single bullet striking the enemy.
        pulse_reset();
        EnemyX = 10'd320; EnemyY = 10'd250; EnemyS = 10'd10;
        base = hits_seen;
        apply_stimulus(1'b1, 300, 250, 8'h00, 8'h7F);
        tick(1);
        ShootBullet = 1'b0;
        tick(30);
        check_output("single_hit_count", 32'(hits_seen - base), 1);
        check_output("single_hit_retired", 32'(BulletActive), 0);

        // Two bullets overlapping the enemy on the same frame.
        pulse_reset();
        enemy_far();
        apply_stimulus(1'b1, 300, 250, 8'h00, 8'h7F);
        tick(1);
        ShootBullet = 1'b0;
        tick(16);
        apply_stimulus(1'b1, 300, 100, 8'h00, 8'h7F);
        tick(1);
        ShootBullet = 1'b0;
        tick(2);
        base = hits_seen;
        EnemyX = 10'd320; EnemyY = 10'd175; EnemyS = 10'd100;
        tick(3);
        check_output("double_hit_one_pulse", 32'(hits_seen - base), 1);
        check_output("double_hit_retired", 32'(BulletActive), 0);
        enemy_far();

        // game_end clears the pool and blocks a launch on the same edge.
        pulse_reset();
        ShootBullet = 1'b1;
        tick(1);
        ShootBullet = 1'b0;
        tick(17);
        game_end = 2'b01;
        ShootBullet = 1'b1;
        tick(1);
        check_output("game_end_cleared", 32'(BulletActive), 0);
        check_output("game_end_no_ack", 32'(fire_ack), 0);
        game_end = 2'b00;
        ShootBullet = 1'b0;
        tick(2);
        ShootBullet = 1'b1;
        tick(1);
        ShootBullet = 1'b0;
        check_output("resume_launch", 32'(BulletActive), 4'b0001);
        check_output("resume_ack", 32'(fire_ack), 1);

        // Randomised play.
        for (int k = 0; k < 3000; k++) begin
            Reset = ($urandom_range(0, 499) == 0);
            game_end = ($urandom_range(0, 299) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 700), $urandom_range(0, 520),
                           8'($urandom), 8'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                EnemyX = 10'($urandom_range(0, 700));
                EnemyY = 10'($urandom_range(0, 520));
                EnemyS = 10'($urandom_range(0, 40));
            end
            tick(1);
        end
        Reset = 1'b0;
        game_end = 2'b00;
        ShootBullet = 1'b0;
        tick(2);
        check_output("fire_queue_drained", 32'(exp_fire.size()), 0);
        check_output("hit_queue_drained", 32'(exp_hit.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
